scd_step_counter: RTL and testbench

Parametrised successor to the SCD exponent/shift-count datapath. It contains a W-bit SCAD adder with an 8-function op select, the FE and SC registers, and status flags. It adds a sequenced step-count loop: SC is loaded, then counted down one per enabled cycle to drive multi-cycle shift/normalize loops, with busy/step/done handshakes. It sits between the microcode decode (op/load/start controls) and the shifter/EBOX loop logic that consumes step pulses.

---
 rtl/scd_step_counter.sv | 167 ++++++++++++++++
 tb/tb_scd_step_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scd_step_counter.sv
`default_nettype none
// ============================================================================
//  Module   : scd_step_counter
//  Brief    : SCAD exponent/shift-count datapath (W-bit adder, FE and SC
//             registers, status flags) with a sequenced SC count-down loop
//             that issues busy/step/done handshakes to the shifter loop.
//  Revision : 1.0  initial release
// ============================================================================
module scd_step_counter #(
    parameter int W         = 10,
    parameter int GE_THRESH = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] scada,
    input  logic [W-1:0] scadb,
    input  logic [2:0]   scad_op,
    input  logic         fe_load,
    input  logic         sc_load,
    input  logic         sc_sel,
    input  logic         start,
    input  logic         step_en,
    input  logic         abort,
    output logic [W-1:0] scad,
    output logic         scad_eq0,
    output logic         scad_sign,
    output logic         scad_ovf,
    output logic [W-1:0] fe,
    output logic [W-1:0] sc,
    output logic         fe_sign,
    output logic         sc_sign,
    output logic         sc_ge_thresh,
    output logic         busy,
    output logic         step,
    output logic         done
);

    localparam logic [1:0]   c_ST_IDLE = 2'd0;
    localparam logic [1:0]   c_ST_RUN  = 2'd1;
    localparam logic [1:0]   c_ST_DONE = 2'd2;

    localparam logic [W-1:0] c_ZERO    = '0;
    localparam logic [W-1:0] c_ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_THRESH  = W'(GE_THRESH);

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [W-1:0] r_fe;
    logic [W-1:0] r_sc;
    logic [W-1:0] w_sc_next;
    logic         w_busy;
    logic         w_step;
    logic         w_done;

    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic [W-1:0] w_scad;
    logic         w_ovf;

    assign w_sum  = scada + scadb;
    assign w_diff = scada - scadb;
    assign w_inc  = scada + c_ONE;
    assign w_dec  = scada - c_ONE;

    // SCAD function select and signed-overflow detection for the arithmetic ops
    always_comb begin
        w_scad = scada;
        w_ovf  = 1'b0;
        case (scad_op)
            3'd0: w_scad = scada;
            3'd1: w_scad = scadb;
            3'd2: begin
                w_scad = w_sum;
                w_ovf  = (scada[W-1] == scadb[W-1]) && (w_sum[W-1] != scada[W-1]);
            end
            3'd3: begin
                w_scad = w_diff;
                w_ovf  = (scada[W-1] != scadb[W-1]) && (w_diff[W-1] != scada[W-1]);
            end
            3'd4: begin
                w_scad = w_inc;
                w_ovf  = !scada[W-1] && w_inc[W-1];
            end
            3'd5: begin
                w_scad = w_dec;
                w_ovf  = scada[W-1] && !w_dec[W-1];
            end
            3'd6: w_scad = scada | scadb;
            default: w_scad = scada & scadb;
        endcase
    end

    // Loop sequencing: next state, next SC and the busy/step/done handshakes
    always_comb begin
        w_state_next = r_state;
        w_sc_next    = r_sc;
        w_busy       = 1'b0;
        w_step       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // start takes precedence over a same-cycle SC load
                if (start) begin
                    if (r_sc[W-1] || (r_sc == c_ZERO)) begin
                        w_state_next = c_ST_DONE;
                    end else begin
                        w_state_next = c_ST_RUN;
                    end
                end else if (sc_load) begin
                    w_sc_next = sc_sel ? r_fe : w_scad;
                end
            end
            c_ST_RUN: begin
                w_busy = 1'b1;
                if (abort) begin
                    // abort wins over step_en: no iteration executed this cycle
                    w_state_next = c_ST_IDLE;
                end else if (step_en) begin
                    w_step    = 1'b1;
                    w_sc_next = r_sc - c_ONE;
                    if (r_sc == c_ONE) begin
                        w_state_next = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_done       = !abort;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State, FE and SC registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_fe    <= c_ZERO;
            r_sc    <= c_ZERO;
        end else begin
            r_state <= w_state_next;
            r_sc    <= w_sc_next;
            if (fe_load) begin
                r_fe <= w_scad;
            end
        end
    end

    assign scad         = w_scad;
    assign scad_eq0     = (w_scad == c_ZERO);
    assign scad_sign    = w_scad[W-1];
    assign scad_ovf     = w_ovf;
    assign fe           = r_fe;
    assign sc           = r_sc;
    assign fe_sign      = r_fe[W-1];
    assign sc_sign      = r_sc[W-1];
    assign sc_ge_thresh = ($signed(r_sc) >= $signed(c_THRESH));
    assign busy         = w_busy;
    assign step         = w_step;
    assign done         = w_done;

endmodule
`default_nettype wire

// File: tb/tb_scd_step_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scd_step_counter
//  Brief    : Directed scoreboard bench for scd_step_counter (W=10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_scd_step_counter;

    localparam int W         = 10;
    localparam int GE_THRESH = 36;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] scada;
    logic [W-1:0] scadb;
    logic [2:0]   scad_op;
    logic         fe_load;
    logic         sc_load;
    logic         sc_sel;
    logic         start;
    logic         step_en;
    logic         abort;
    logic [W-1:0] scad;
    logic         scad_eq0;
    logic         scad_sign;
    logic         scad_ovf;
    logic [W-1:0] fe;
    logic [W-1:0] sc;
    logic         fe_sign;
    logic         sc_sign;
    logic         sc_ge_thresh;
    logic         busy;
    logic         step;
    logic         done;

    scd_step_counter #(.W(W), .GE_THRESH(GE_THRESH)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scada       (scada),
        .scadb       (scadb),
        .scad_op     (scad_op),
        .fe_load     (fe_load),
        .sc_load     (sc_load),
        .sc_sel      (sc_sel),
        .start       (start),
        .step_en     (step_en),
        .abort       (abort),
        .scad        (scad),
        .scad_eq0    (scad_eq0),
        .scad_sign   (scad_sign),
        .scad_ovf    (scad_ovf),
        .fe          (fe),
        .sc          (sc),
        .fe_sign     (fe_sign),
        .sc_sign     (sc_sign),
        .sc_ge_thresh(sc_ge_thresh),
        .busy        (busy),
        .step        (step),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: expectations queued at stimulus time, consumed at observation
    string       r_tag_q[$];
    logic [31:0] r_exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic push(input string tag, input logic [31:0] val);
        r_tag_q.push_back(tag);
        r_exp_q.push_back(val);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (r_exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty observed=0x%0h required=<none>", obs);
        end else begin
            t = r_tag_q.pop_front();
            e = r_exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s observed=0x%0h required=0x%0h", t, obs, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sc(input logic [W-1:0] v);
        scada   = v;
        scad_op = 3'd0;
        sc_sel  = 1'b0;
        sc_load = 1'b1;
        cyc();
        sc_load = 1'b0;
    endtask

    // Starts the loop and observes it for up to 40 cycles. Steps are counted
    // only on non-abort cycles; the stall window holds step_en low.
    task automatic run_loop(input int stall_at, input int stall_len, input int abort_after,
                            input bit load_with_start, input logic [W-1:0] load_val,
                            output int steps, output int busy_cyc, output int done_at,
                            output logic [W-1:0] stall_sc);
        bit aborted;
        steps    = 0;
        busy_cyc = 0;
        done_at  = -1;
        stall_sc = '0;
        aborted  = 1'b0;
        start    = 1'b1;
        if (load_with_start) begin
            scada   = load_val;
            scad_op = 3'd0;
            sc_sel  = 1'b0;
            sc_load = 1'b1;
        end
        cyc();
        start   = 1'b0;
        sc_load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step_en = !(k >= stall_at && k < stall_at + stall_len);
            abort   = 1'b0;
            if (abort_after >= 0 && !aborted && steps == abort_after) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            #1;
            if (k == stall_at + stall_len - 1) stall_sc = sc;
            if (step && !abort) steps++;
            if (busy) busy_cyc++;
            if (done) begin
                done_at = k;
                cyc();
                break;
            end
            cyc();
        end
        step_en = 1'b0;
        abort   = 1'b0;
    endtask

    int           steps;
    int           busy_cyc;
    int           done_at;
    logic [W-1:0] stall_sc;

    initial begin
        rst_n   = 1'b0;
        scada   = 10'h155;
        scadb   = 10'h0AA;
        scad_op = 3'd0;
        fe_load = 1'b1;
        sc_load = 1'b1;
        sc_sel  = 1'b0;
        start   = 1'b0;
        step_en = 1'b0;
        abort   = 1'b0;

        // Reset with loads asserted
        push("rst_fe", 32'h0);  push("rst_sc", 32'h0);  push("rst_busy", 32'h0);
        push("rst_done", 32'h0); push("rst_ge", 32'h0);
        cyc();
        pop_check(fe); pop_check(sc); pop_check(busy); pop_check(done); pop_check(sc_ge_thresh);
        rst_n   = 1'b1;
        fe_load = 1'b0;
        sc_load = 1'b0;

        // SCAD add overflow
        scada = 10'h1FF; scadb = 10'h001; scad_op = 3'd2;
        push("add_scad", 32'h200); push("add_sign", 32'h1); push("add_ovf", 32'h1); push("add_eq0", 32'h0);
        #1;
        pop_check(scad); pop_check(scad_sign); pop_check(scad_ovf); pop_check(scad_eq0);

        // SCAD subtract overflow: most-negative minus one
        scada = 10'h200; scadb = 10'h001; scad_op = 3'd3;
        push("sub_scad", 32'h1FF); push("sub_ovf", 32'h1);
        #1;
        pop_check(scad); pop_check(scad_ovf);

        // SCAD decrement through zero: no overflow
        scada = 10'h000; scad_op = 3'd5;
        push("dec_scad", 32'h3FF); push("dec_ovf", 32'h0);
        #1;
        pop_check(scad); pop_check(scad_ovf);

        // SCAD AND giving zero
        scada = 10'h0F0; scadb = 10'h00F; scad_op = 3'd7;
        push("and_eq0", 32'h1); push("and_ovf", 32'h0);
        #1;
        pop_check(scad_eq0); pop_check(scad_ovf);

        // FE load, then joint load with SC taking the old FE
        scada = 10'h007; scad_op = 3'd0; fe_load = 1'b1;
        push("fe_load", 32'h007);
        cyc();
        pop_check(fe);
        scada = 10'h211; sc_sel = 1'b1; sc_load = 1'b1;
        push("joint_fe", 32'h211); push("joint_sc", 32'h007); push("joint_fe_sign", 32'h1);
        cyc();
        fe_load = 1'b0; sc_load = 1'b0; sc_sel = 1'b0;
        pop_check(fe); pop_check(sc); pop_check(fe_sign);

        // Loop of 5, step_en constant
        load_sc(10'd5);
        push("run5_steps", 32'd5); push("run5_busy", 32'd5); push("run5_done_at", 32'd5); push("run5_sc", 32'd0);
        run_loop(100, 0, -1, 1'b0, '0, steps, busy_cyc, done_at, stall_sc);
        pop_check(steps); pop_check(busy_cyc); pop_check(done_at); pop_check(sc);

        // Loop of 5 with a 3-cycle stall after two steps
        load_sc(10'd5);
        push("stall_steps", 32'd5); push("stall_busy", 32'd8); push("stall_done_at", 32'd8);
        push("stall_sc_hold", 32'd3); push("stall_sc", 32'd0);
        run_loop(2, 3, -1, 1'b0, '0, steps, busy_cyc, done_at, stall_sc);
        pop_check(steps); pop_check(busy_cyc); pop_check(done_at); pop_check(stall_sc); pop_check(sc);

        // Negative SC: immediate done, no steps
        load_sc(10'h3FD);
        push("neg_sign", 32'h1);
        pop_check(sc_sign);
        push("neg_steps", 32'd0); push("neg_done_at", 32'd0); push("neg_sc", 32'h3FD);
        run_loop(100, 0, -1, 1'b0, '0, steps, busy_cyc, done_at, stall_sc);
        pop_check(steps); pop_check(done_at); pop_check(sc);

        // Threshold edges
        load_sc(10'd36);
        push("ge_36", 32'h1);
        pop_check(sc_ge_thresh);
        load_sc(10'd35);
        push("ge_35", 32'h0);
        pop_check(sc_ge_thresh);

        // Abort after 3 steps of 8
        load_sc(10'd8);
        push("abort_steps", 32'd3); push("abort_done_at", 32'hFFFF_FFFF); push("abort_sc", 32'd5);
        run_loop(100, 0, 3, 1'b0, '0, steps, busy_cyc, done_at, stall_sc);
        pop_check(steps); pop_check(done_at); pop_check(sc);

        // Start with a same-cycle SC load: load ignored
        load_sc(10'd2);
        push("startld_steps", 32'd2); push("startld_done_at", 32'd2); push("startld_sc", 32'd0);
        run_loop(100, 0, -1, 1'b1, 10'd9, steps, busy_cyc, done_at, stall_sc);
        pop_check(steps); pop_check(done_at); pop_check(sc);

        // Reset mid-loop: back to IDLE with no done
        load_sc(10'd4);
        start = 1'b1;
        cyc();
        start   = 1'b0;
        step_en = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        push("midrst_busy", 32'h0); push("midrst_sc", 32'h0);
        cyc();
        pop_check(busy); pop_check(sc);
        rst_n = 1'b1;
        push("midrst_done", 32'h0);
        cyc();
        pop_check(done);
        step_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
